// File: rtl/div.sv
// Multi-cycle restoring divider (32/32 -> 32 quotient, 32 remainder), signed or unsigned.
// Optional macro DIV_SPECIAL_FAST_EN: divide-by-zero and signed overflow finish in one cycle.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   divisor;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   dividend_orig;
  logic           neg_quo;
  logic           neg_rem;
  logic           special_zero;
  logic           special_ovf;

  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic           op_zero;
  logic           op_ovf;
  logic [W:0]     shifted;
  logic           ge;
  logic [W-1:0]   rem_next;
  logic [W-1:0]   quo_next;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;
  logic [2*W-1:0] final_result;

  // Operand conditioning and special-case detection at acceptance.
  always_comb begin
    a_neg   = signed_div_i & opdata1_i[W-1];
    b_neg   = signed_div_i & opdata2_i[W-1];
    a_mag   = a_neg ? W'(-opdata1_i) : opdata1_i;
    b_mag   = b_neg ? W'(-opdata2_i) : opdata2_i;
    op_zero = (opdata2_i == '0);
    op_ovf  = signed_div_i && (opdata1_i == 32'h8000_0000) && (opdata2_i == 32'hFFFF_FFFF);
  end

  // One restoring step: dividend bits shift out of quo into rem, quotient bits shift in.
  always_comb begin
    shifted  = {rem, quo[W-1]};
    ge       = (shifted >= {1'b0, divisor});
    rem_next = ge ? W'(shifted - {1'b0, divisor}) : shifted[W-1:0];
    quo_next = {quo[W-2:0], ge};
  end

  // Sign correction plus fixed results for the special cases.
  always_comb begin
    q_fix = neg_quo ? W'(-quo) : quo;
    r_fix = neg_rem ? W'(-rem) : rem;
    if (special_zero)
      final_result = {dividend_orig, 32'hFFFF_FFFF};
    else if (special_ovf)
      final_result = {32'h0000_0000, 32'h8000_0000};
    else
      final_result = {r_fix, q_fix};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= DivFree;
      cnt           <= '0;
      ready_o       <= 1'b0;
      result_o      <= '0;
      divisor       <= '0;
      quo           <= '0;
      rem           <= '0;
      dividend_orig <= '0;
      neg_quo       <= 1'b0;
      neg_rem       <= 1'b0;
      special_zero  <= 1'b0;
      special_ovf   <= 1'b0;
    end else begin
      case (state)
        DivFree: begin
          ready_o <= 1'b0;
          if (start_i && !annul_i) begin
            quo           <= a_mag;
            rem           <= '0;
            divisor       <= b_mag;
            dividend_orig <= opdata1_i;
            neg_quo       <= a_neg ^ b_neg;
            neg_rem       <= a_neg;
            special_zero  <= op_zero;
            special_ovf   <= op_ovf;
            cnt           <= '0;
`ifdef DIV_SPECIAL_FAST_EN
            state         <= (op_zero || op_ovf) ? DivByZero : DivOn;
`else
            state         <= DivOn;
`endif
          end
        end
`ifdef DIV_SPECIAL_FAST_EN
        DivByZero: begin
          if (annul_i || !start_i) begin
            state <= DivFree;
          end else begin
            result_o <= final_result;
            ready_o  <= 1'b1;
            state    <= DivEnd;
          end
        end
`endif
        DivOn: begin
          if (annul_i || !start_i) begin
            state <= DivFree;
          end else if (cnt != CW'(W)) begin
            quo <= quo_next;
            rem <= rem_next;
            cnt <= cnt + CW'(1);
          end else begin
            result_o <= final_result;
            ready_o  <= 1'b1;
            state    <= DivEnd;
          end
        end
        DivEnd: begin
          if (!start_i) begin
            ready_o <= 1'b0;
            state   <= DivFree;
          end
        end
        default: begin
          ready_o <= 1'b0;
          state   <= DivFree;
        end
      endcase
    end
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have a single clock and a reset that is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset (RstEnable = 1).
REQ-004 signed_div_i  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-005 opdata1_i  input  32  dividend.
REQ-006 opdata2_i  input  32  divisor.
REQ-007 start_i  input  1  request; held high by EX until ready_o is seen.
REQ-008 annul_i  input  1  cancel the operation in flight (flush).
REQ-009 result_o  output  64  {remainder[63:32], quotient[31:0]}.
REQ-010 ready_o  output  1  result_o valid.

Function
REQ-011 The block SHALL implement FSM states DivFree, DivByZero, DivOn and DivEnd, plus a 6-bit iteration counter cnt.
REQ-012 In DivFree with start_i=1 and annul_i=0, the block SHALL latch the operands at that edge (E0), converting negative operands to magnitude when signed_div_i=1, clear cnt and enter DivOn; operand changes after E0 are ignored.
REQ-013 In DivOn, each edge with cnt<32 SHALL perform one restoring shift-subtract step and increment cnt.
REQ-014 In DivOn, the edge with cnt==32 SHALL apply sign correction, load result_o, set ready_o=1 and enter DivEnd, so ready_o first reads high after edge E33.
REQ-015 Sign rules: quotient negated when signed_div_i=1 and the operand signs differ; remainder takes the sign of the dividend.
REQ-016 Divisor 0 SHALL produce quotient 0xFFFFFFFF and remainder equal to the original dividend, for both signed and unsigned operation.
REQ-017 Signed 0x80000000 / 0xFFFFFFFF SHALL produce quotient 0x80000000 and remainder 0.
REQ-018 In DivEnd, result_o and ready_o SHALL hold while start_i=1; start_i=0 SHALL return the block to DivFree with ready_o=0 at the next edge.
REQ-019 In DivOn or DivByZero, annul_i=1 or start_i=0 SHALL abort to DivFree at the next edge; ready_o stays 0 and no result is produced.
REQ-020 Annul_i SHALL take priority over start_i in DivFree, so no operation is accepted.
REQ-021 result_o SHALL change only on entry to DivEnd or on reset.

Reset
REQ-022 When rst=1 at a rising edge, the block SHALL set state=DivFree, cnt=0, ready_o=0 and result_o=0, overriding all other inputs including a mid-operation reset.
REQ-023 The first start_i after reset is released SHALL be accepted normally.

Configuration
REQ-024 With DIV_SPECIAL_FAST_EN defined, a divisor of 0 or signed overflow (REQ-017) detected at E0 SHALL enter DivByZero and then DivEnd at E1 with the REQ-016/017 result, so ready_o is high after E1.
REQ-025 With DIV_SPECIAL_FAST_EN undefined, DivByZero SHALL be unreachable, and the special cases SHALL run the full 33-edge path with the result fixed up at the cnt==32 edge to the same REQ-016/017 values.

Verification
REQ-026 Unsigned 100/7, start held -> ready_o high after E33, result_o={0x00000002,0x0000000E}; start_i dropped -> ready_o=0 next edge.
REQ-027 Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-028 Divide by zero: unsigned 5/0 -> {0x00000005,0xFFFFFFFF}; signed -5/0 -> {0xFFFFFFFB,0xFFFFFFFF}; ready_o after E1 with DIV_SPECIAL_FAST_EN, after E33 without.
REQ-029 Signed 0x80000000/0xFFFFFFFF -> {0x00000000,0x80000000}, with the same latency rule as REQ-028.
REQ-030 annul_i pulsed at E10 of 100/7 -> ready_o never rises and the FSM is in DivFree; a following unsigned 20/3 -> {0x00000002,0x00000006} after E33.
REQ-031 rst asserted at E15 of an operation -> result_o=0, ready_o=0, DivFree; a later 9/3 -> {0x00000000,0x00000003}.
